win_scan_ctrl: RTL and testbench
================================

# win_scan_ctrl

Raster-scan sequencer for the 11×11 window generator (`block11x11`) in the SIFT front end. It accepts a pixel stream under a valid/ready handshake and tracks the row and column of every accepted pixel. It drives the generator's shift enable and flags each cycle in which the generator's 11 output rows form a window lying fully inside the image, tagged with the window-centre coordinates. It brackets each frame with start/busy/done signalling so that downstream detectors (DoG, extremum) can be scheduled per frame.

## Interface
Parameters:
- `IMG_W`, 640: image width in pixels; must be ≥ `WIN`.
- `IMG_H`, 480: image height in lines; must be ≥ `WIN`.
- `WIN`, 11: window size, odd; `HALF` = (`WIN`-1)/2.
- `CNT_W`, 21: pixel counter width; `IMG_W`*`IMG_H` ≤ 2^`CNT_W`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-low reset.
- `frame_start`  in  1  one-cycle request to begin a frame.
- `pix_valid`  in  1  upstream pixel present.
- `pix_ready`  out  1  controller can accept a pixel.
- `ds_ready`  in  1  downstream can take a window this cycle.
- `shift_en`  out  1  advance `block11x11` by one pixel (= `pix_valid` & `pix_ready`).
- `win_valid`  out  1  current generator output is a full in-image window.
- `win_x`  out  clog2(`IMG_W`)  window centre column.
- `win_y`  out  clog2(`IMG_H`)  window centre row.
- `pix_cnt`  out  `CNT_W`  pixels accepted this frame.
- `busy`  out  1  frame in progress.
- `frame_done`  out  1  one-cycle pulse after the last pixel.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on `frame_start`. On entry, `col`, `row` and `pix_cnt` are cleared.
- In RUN, `pix_ready` = `ds_ready`. In IDLE and DONE, `pix_ready` = 0.
- Accept = `pix_valid` & `pix_ready`. Each accept:
  - drives `shift_en` combinationally in the same cycle;
  - increments `pix_cnt`;
  - advances `col`. When `col` = `IMG_W`-1, `col` wraps to 0 and `row` increments.
- Window rule. The accepted pixel at (`row`, `col`) completes the window centred at (`row`-`HALF`, `col`-`HALF`). That window is valid when `row` ≥ `WIN`-1 and `col` ≥ `WIN`-1. Windows straddling the row wrap are never flagged.
- Accepting the pixel at (`IMG_H`-1, `IMG_W`-1) moves the state to DONE. DONE lasts one cycle, during which `frame_done` = 1, then the state returns to IDLE.
- `frame_start` in RUN or DONE is ignored.
- Windows per frame = (`IMG_W`-`WIN`+1)*(`IMG_H`-`WIN`+1).
- `pix_cnt` holds its final value in IDLE until the next `frame_start`.

## Timing
- Reset values (`rst` = 0 at a clock edge): state IDLE; `pix_ready`, `shift_en`, `win_valid`, `busy`, `frame_done` = 0; `win_x`, `win_y`, `pix_cnt` = 0.
- `win_valid`, `win_x` and `win_y` are registered. They are asserted the cycle after the accept that completes the window, aligned with `block11x11`'s registered outputs.
- `win_valid` stays high for exactly one cycle per window and is 0 in any cycle without a preceding accept.
- `busy` goes high the cycle after `frame_start` and stays high through DONE.
- `frame_done` asserts the cycle after the last accept, coincident with the last `win_valid`.
- `ds_ready` low freezes all counters. `pix_valid` low with `ds_ready` high inserts a bubble with no state change.
- `rst` asserted mid-frame aborts at the next edge: all outputs return to reset values, and no `frame_done` is issued.
- `frame_start` in the same cycle as the last accept is ignored. A new frame requires `frame_start` in IDLE.

## Structure
- Shared package `sift_pkg`:
  - `WIN` and `HALF` constants;
  - the state enum (IDLE/RUN/DONE);
  - a `clog2` function.
- One natural sub-module, `raster_cnt`: the `col`/`row` counter with wrap, an enable input, and a last-pixel flag.
- The FSM, window compare and output registers live in the top level.

## Test plan
- Small frame, `IMG_W`=16, `IMG_H`=12, continuous `pix_valid` and `ds_ready` → 12 `win_valid` pulses. The first has (`win_x`, `win_y`) = (5,5), the last (10,6). `pix_cnt`=192. `frame_done` fires once, the cycle after accept #192.
- Same frame with `ds_ready` toggled 1/0 and random `pix_valid` gaps → same 12 windows in the same order. No `shift_en` while `pix_ready`=0, and `pix_cnt` frozen during stalls.
- Row wrap, 16×12 → no `win_valid` for `col` 0–9 of any row. The first window of row 11 has `win_x`=5, `win_y`=6.
- `frame_start` pulsed mid-frame and again coincident with the last accept → ignored; exactly one `frame_done`, 192 accepts.
- `rst` low after 100 accepts, then `frame_start` → `busy`/`win_valid`/`pix_cnt` at 0 after the reset edge. The next frame again yields 12 windows starting at (5,5).
- Minimum frame, `IMG_W`=`IMG_H`=11 → a single `win_valid` with (5,5), asserted in the same cycle as `frame_done`.

Source files
------------

// File: rtl/sift_pkg.sv
// rtl/sift_pkg.sv - shared SIFT front-end constants, scan state enum and clog2 helper
package sift_pkg;

  localparam int WIN  = 11;
  localparam int HALF = (WIN - 1) / 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } scan_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/win_scan_ctrl_if.sv
// rtl/win_scan_ctrl_if.sv - pixel handshake, window tag and frame status bundle of win_scan_ctrl
interface win_scan_ctrl_if
  import sift_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CNT_W = 21
);

  localparam int XW = clog2(IMG_W);
  localparam int YW = clog2(IMG_H);

  logic             frame_start;
  logic             pix_valid;
  logic             pix_ready;
  logic             ds_ready;
  logic             shift_en;
  logic             win_valid;
  logic [XW-1:0]    win_x;
  logic [YW-1:0]    win_y;
  logic [CNT_W-1:0] pix_cnt;
  logic             busy;
  logic             frame_done;

  modport master (
    output frame_start, pix_valid, ds_ready,
    input  pix_ready, shift_en, win_valid, win_x, win_y, pix_cnt, busy, frame_done
  );

  modport slave (
    input  frame_start, pix_valid, ds_ready,
    output pix_ready, shift_en, win_valid, win_x, win_y, pix_cnt, busy, frame_done
  );

endinterface

// File: rtl/win_scan_ctrl_raster_cnt.sv
// rtl/win_scan_ctrl_raster_cnt.sv - column/row raster counter with line wrap and last-pixel flag
module raster_cnt
  import sift_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int XW    = clog2(IMG_W),
  parameter int YW    = clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [XW-1:0] col,
  output logic [YW-1:0] row,
  output logic          last
);

  logic [XW-1:0] col_q, col_d;
  logic [YW-1:0] row_q, row_d;
  logic          col_end;
  logic          row_end;

  assign col_end = (col_q == XW'(IMG_W - 1));
  assign row_end = (row_q == YW'(IMG_H - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (en) begin
      if (col_end) begin
        col_d = '0;
        // wrapping after the last line keeps row inside its range between frames
        row_d = row_end ? '0 : row_q + YW'(1);
      end else begin
        col_d = col_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign last = col_end && row_end;

endmodule

// File: rtl/win_scan_ctrl.sv
// rtl/win_scan_ctrl.sv - raster-scan sequencer for the 11x11 window generator: frame FSM and window tagging
module win_scan_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int WIN   = sift_pkg::WIN,
  parameter int CNT_W = 21
) (
  input  logic            clk,
  input  logic            rst,
  win_scan_ctrl_if.slave  bus
);

  localparam int XW   = sift_pkg::clog2(IMG_W);
  localparam int YW   = sift_pkg::clog2(IMG_H);
  localparam int HALF = (WIN - 1) / 2;

  sift_pkg::scan_state_t state_q, state_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic             win_valid_q, win_valid_d;
  logic [XW-1:0]    win_x_q, win_x_d;
  logic [YW-1:0]    win_y_q, win_y_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;

  logic [XW-1:0]    col;
  logic [YW-1:0]    row;
  logic             last_pix;
  logic             pix_ready;
  logic             accept;
  logic             start;
  logic             win_hit;

  assign pix_ready = (state_q == sift_pkg::ST_RUN) && bus.ds_ready;
  assign accept    = bus.pix_valid && pix_ready;
  assign start     = (state_q == sift_pkg::ST_IDLE) && bus.frame_start;

  raster_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_raster_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (start),
    .en   (accept),
    .col  (col),
    .row  (row),
    .last (last_pix)
  );

  // the accepted pixel is the bottom-right corner of the window it completes
  assign win_hit = accept && (col >= XW'(WIN - 1)) && (row >= YW'(WIN - 1));

  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    win_valid_d = win_hit;
    win_x_d     = win_x_q;
    win_y_d     = win_y_q;
    case (state_q)
      sift_pkg::ST_IDLE: if (bus.frame_start) state_d = sift_pkg::ST_RUN;
      sift_pkg::ST_RUN:  if (accept && last_pix) state_d = sift_pkg::ST_DONE;
      sift_pkg::ST_DONE: state_d = sift_pkg::ST_IDLE;
      default:           state_d = sift_pkg::ST_IDLE;
    endcase
    if (start) begin
      pix_cnt_d = '0;
    end else if (accept) begin
      pix_cnt_d = pix_cnt_q + CNT_W'(1);
    end
    if (win_hit) begin
      win_x_d = col - XW'(HALF);
      win_y_d = row - YW'(HALF);
    end
    busy_d       = (state_d != sift_pkg::ST_IDLE);
    frame_done_d = (state_d == sift_pkg::ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= sift_pkg::ST_IDLE;
      pix_cnt_q    <= '0;
      win_valid_q  <= 1'b0;
      win_x_q      <= '0;
      win_y_q      <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      win_valid_q  <= win_valid_d;
      win_x_q      <= win_x_d;
      win_y_q      <= win_y_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.pix_ready  = pix_ready;
  assign bus.shift_en   = accept;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_x      = win_x_q;
  assign bus.win_y      = win_y_q;
  assign bus.pix_cnt    = pix_cnt_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_win_scan_ctrl.sv
// tb/tb_win_scan_ctrl.sv - scoreboard bench for win_scan_ctrl on a 16x12 and an 11x11 frame
module tb_win_scan_ctrl;

  typedef struct {
    int x;
    int y;
  } win_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  win_scan_ctrl_if #(.IMG_W(16), .IMG_H(12), .CNT_W(21)) bus_a ();
  win_scan_ctrl_if #(.IMG_W(11), .IMG_H(11), .CNT_W(21)) bus_b ();

  win_scan_ctrl #(.IMG_W(16), .IMG_H(12), .WIN(11), .CNT_W(21)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  win_scan_ctrl #(.IMG_W(11), .IMG_H(11), .WIN(11), .CNT_W(21)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  int   errors = 0;
  int   checks = 0;
  win_t exp_a[$];
  win_t exp_b[$];

  int   a_row, a_col, a_cnt, a_wins, a_dones;
  bit   a_exp_win;
  int   b_wins, b_dones;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic monitor();
    win_t e;
    bit   acc;
    forever begin
      @(negedge clk);
      if (!rst) begin
        a_row = 0; a_col = 0; a_cnt = 0; a_exp_win = 0;
      end else begin
        check("a_shift_en", bus_a.shift_en, bus_a.pix_valid & bus_a.pix_ready);
        if (!bus_a.ds_ready) check("a_stall_ready", bus_a.pix_ready, 0);
        if (!bus_a.busy || bus_a.frame_done) check("a_ready_idle", bus_a.pix_ready, 0);
        check("a_win_timing", bus_a.win_valid, a_exp_win);
        if (bus_a.win_valid) begin
          a_wins++;
          check("a_win_expected", exp_a.size() != 0, 1);
          if (exp_a.size() != 0) begin
            e = exp_a.pop_front();
            check("a_win_x", bus_a.win_x, e.x);
            check("a_win_y", bus_a.win_y, e.y);
          end
        end
        if (bus_a.frame_done) begin
          a_dones++;
          check("a_done_with_win", bus_a.win_valid, 1);
          check("a_done_pix_cnt", bus_a.pix_cnt, 192);
          check("a_done_queue_empty", exp_a.size(), 0);
        end
        if (bus_a.busy) check("a_pix_cnt_track", bus_a.pix_cnt, a_cnt);
        if (bus_a.frame_start && !bus_a.busy) begin
          a_row = 0; a_col = 0; a_cnt = 0;
        end
        acc = bus_a.pix_valid && bus_a.pix_ready;
        a_exp_win = acc && (a_row >= 10) && (a_col >= 10);
        if (acc) begin
          a_cnt++;
          if (a_col == 15) begin
            a_col = 0;
            a_row++;
          end else begin
            a_col++;
          end
        end

        if (bus_b.win_valid) begin
          b_wins++;
          check("b_win_expected", exp_b.size() != 0, 1);
          if (exp_b.size() != 0) begin
            e = exp_b.pop_front();
            check("b_win_x", bus_b.win_x, e.x);
            check("b_win_y", bus_b.win_y, e.y);
          end
        end
        if (bus_b.frame_done) begin
          b_dones++;
          check("b_done_with_win", bus_b.win_valid, 1);
          check("b_done_pix_cnt", bus_b.pix_cnt, 121);
        end
      end
    end
  endtask

  // mode 0: continuous; 1: ds_ready toggling with pix_valid gaps; 2: stray frame_start pulses
  task automatic frame_a(input int mode);
    int d0, w0, n;
    d0 = a_dones;
    w0 = a_wins;
    for (int yi = 5; yi <= 6; yi++)
      for (int xi = 5; xi <= 10; xi++) exp_a.push_back('{x: xi, y: yi});
    bus_a.frame_start = 1'b1;
    bus_a.pix_valid   = 1'b0;
    bus_a.ds_ready    = 1'b1;
    @(posedge clk); #1;
    bus_a.frame_start = 1'b0;
    check("a_busy_after_start", bus_a.busy, 1);
    n = 0;
    while (a_dones == d0 && n < 3000) begin
      bus_a.pix_valid   = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus_a.ds_ready    = (mode == 1) ? ((n % 2) == 0) : 1'b1;
      bus_a.frame_start = (mode == 2) && (a_cnt == 50 || a_cnt == 191);
      @(posedge clk); #1;
      n++;
    end
    bus_a.pix_valid   = 1'b0;
    bus_a.frame_start = 1'b0;
    bus_a.ds_ready    = 1'b1;
    check("a_frame_timeout", n < 3000, 1);
    check("a_busy_after_done", bus_a.busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("a_done_count", a_dones - d0, 1);
    check("a_win_count", a_wins - w0, 12);
    check("a_pix_cnt_hold", bus_a.pix_cnt, 192);
    check("a_leftover_windows", exp_a.size(), 0);
  endtask

  task automatic abort_a();
    int d0, n;
    bus_a.frame_start = 1'b1;
    bus_a.pix_valid   = 1'b0;
    bus_a.ds_ready    = 1'b1;
    @(posedge clk); #1;
    bus_a.frame_start = 1'b0;
    n = 0;
    while (a_cnt < 100 && n < 500) begin
      bus_a.pix_valid = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    check("a_abort_timeout", n < 500, 1);
    d0  = a_dones;
    rst = 1'b0;
    @(posedge clk); #1;
    check("a_abort_busy", bus_a.busy, 0);
    check("a_abort_win_valid", bus_a.win_valid, 0);
    check("a_abort_pix_cnt", bus_a.pix_cnt, 0);
    check("a_abort_pix_ready", bus_a.pix_ready, 0);
    rst = 1'b1;
    bus_a.pix_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("a_abort_no_done", a_dones - d0, 0);
  endtask

  task automatic frame_b();
    int d0, w0, n;
    d0 = b_dones;
    w0 = b_wins;
    exp_b.push_back('{x: 5, y: 5});
    bus_b.frame_start = 1'b1;
    bus_b.pix_valid   = 1'b0;
    bus_b.ds_ready    = 1'b1;
    @(posedge clk); #1;
    bus_b.frame_start = 1'b0;
    n = 0;
    while (b_dones == d0 && n < 1000) begin
      bus_b.pix_valid = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    bus_b.pix_valid = 1'b0;
    check("b_frame_timeout", n < 1000, 1);
    repeat (3) @(posedge clk);
    #1;
    check("b_done_count", b_dones - d0, 1);
    check("b_win_count", b_wins - w0, 1);
    check("b_pix_cnt_hold", bus_b.pix_cnt, 121);
    check("b_busy_idle", bus_b.busy, 0);
  endtask

  initial begin
    rst = 1'b0;
    bus_a.frame_start = 1'b0; bus_a.pix_valid = 1'b1; bus_a.ds_ready = 1'b1;
    bus_b.frame_start = 1'b0; bus_b.pix_valid = 1'b1; bus_b.ds_ready = 1'b1;
    a_wins = 0; a_dones = 0; b_wins = 0; b_dones = 0;
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    #1;
    check("rst_pix_ready", bus_a.pix_ready, 0);
    check("rst_shift_en", bus_a.shift_en, 0);
    check("rst_win_valid", bus_a.win_valid, 0);
    check("rst_busy", bus_a.busy, 0);
    check("rst_frame_done", bus_a.frame_done, 0);
    check("rst_win_x", bus_a.win_x, 0);
    check("rst_win_y", bus_a.win_y, 0);
    check("rst_pix_cnt", bus_a.pix_cnt, 0);
    check("rst_b_pix_ready", bus_b.pix_ready, 0);
    rst = 1'b1;
    bus_a.pix_valid = 1'b0;
    bus_b.pix_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    frame_a(0);
    frame_a(1);
    frame_a(2);
    abort_a();
    frame_a(0);
    frame_b();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
